// File: rtl/dut_run_controller.sv
// dut_run_controller: sequences the core reset, counts RUN cycles and retired
// instructions, snoops tohost writes for a pass/fail verdict, enforces a cycle
// timeout and latches the final verdict until the next start request.
// Ports:
//   clk, rst                    - clock; async active-high reset
//   start                       - level request to (re)start a run (IDLE/DONE only)
//   retire_valid                - one instruction retired this cycle
//   mem_we, mem_addr, mem_wdata - data-memory write snoop
//   dut_rst                     - registered reset to the core
//   busy                        - decoded from state: RESET or RUN
//   done, pass, timeout         - registered verdict flags
//   fail_code                   - test number (tohost word >> 1) on failure
//   cycle_count, instret        - RUN-cycle and retired-instruction counters
module dut_run_controller #(
  parameter int                RST_CYCLES  = 4,
  parameter int                TIMEOUT     = 100000,
  parameter int                CNT_W       = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              retire_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              dut_rst,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-2:0] fail_code,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RESET = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  logic [1:0]      state;
  logic [RC_W-1:0] rst_cnt;

  logic start_run;
  logic hit;
  logic hit_term;
  logic hit_pass;
  logic at_limit;

  // start is only honoured when no run is in progress
  assign start_run = start && (state == IDLE || state == DONE);

  // Only odd tohost words end the run; even words are progress reports.
  assign hit      = mem_we && (mem_addr == TOHOST_ADDR);
  assign hit_term = hit && mem_wdata[0];
  assign hit_pass = (mem_wdata == DATA_W'(1));
  assign at_limit = (cycle_count == CNT_W'(TIMEOUT - 1));

  assign busy = (state == RESET) || (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rst_cnt     <= '0;
      dut_rst     <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      instret     <= '0;
    end else if (start_run) begin
      state       <= RESET;
      rst_cnt     <= RC_W'(RST_CYCLES);
      dut_rst     <= 1'b1;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
      instret     <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_rst <= 1'b1;
        end
        RESET: begin
          // Leaving on the count of 1 gives the core exactly RST_CYCLES
          // edges of reset after the start edge.
          if (rst_cnt == RC_W'(1)) begin
            state   <= RUN;
            dut_rst <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        RUN: begin
          cycle_count <= cycle_count + CNT_W'(1);
          if (retire_valid) begin
            instret <= instret + CNT_W'(1);
          end
          // A terminating hit takes priority over the timeout.
          if (hit_term) begin
            state   <= DONE;
            done    <= 1'b1;
            dut_rst <= 1'b1;
            pass    <= hit_pass;
            if (!hit_pass) begin
              fail_code <= mem_wdata[DATA_W-1:1];
            end
          end else if (at_limit) begin
            state   <= DONE;
            done    <= 1'b1;
            dut_rst <= 1'b1;
            timeout <= 1'b1;
          end
        end
        DONE: begin
          // verdict and counters hold; core stays frozen in reset
          dut_rst <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          dut_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule
